// File: rtl/movimiento_jugador.sv
// Player x-position controller: synchronized left/right requests drive a
// REPOSO/DER/IZQ FSM that steps a saturating position at a fixed tick rate.
module movimiento_jugador #(
    parameter int TICK_DIV = 500000,
    parameter int STEP     = 8,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = 632,
    parameter int POS_INIT = 316
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       derecha,
    input  logic       izquierda,
    input  logic       icentrar,
    output logic [9:0] posicion,
    output logic       moviendo,
    output logic       direccion,
    output logic       pulso_paso,
    output logic       borde_izq,
    output logic       borde_der
);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        DER    = 2'd1,
        IZQ    = 2'd2
    } estado_t;

    localparam logic [19:0] CNT_LAST = 20'(TICK_DIV - 1);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] MIN_W    = 11'(POS_MIN);
    localparam logic [10:0] MAX_W    = 11'(POS_MAX);
    localparam logic [9:0]  MIN_P    = 10'(POS_MIN);
    localparam logic [9:0]  MAX_P    = 10'(POS_MAX);
    localparam logic [9:0]  INIT_P   = 10'(POS_INIT);

    logic        d_meta;
    logic        d_s;
    logic        i_meta;
    logic        i_s;
    estado_t     estado;
    estado_t     estado_sig;
    logic [19:0] cuenta;
    logic [10:0] pos_ext;
    logic [10:0] suma;
    logic [9:0]  pos_der;
    logic [9:0]  pos_izq;
    logic [9:0]  pos_paso;
    logic        paso;

    // Two-flop synchronizers for the asynchronous move requests
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            d_meta <= 1'b0;
            d_s    <= 1'b0;
            i_meta <= 1'b0;
            i_s    <= 1'b0;
        end else begin
            d_meta <= derecha;
            d_s    <= d_meta;
            i_meta <= izquierda;
            i_s    <= i_meta;
        end
    end

    // Next state: exactly one request selects a direction, otherwise rest
    always_comb begin
        estado_sig = REPOSO;
        if (d_s && !i_s) begin
            estado_sig = DER;
        end else if (i_s && !d_s) begin
            estado_sig = IZQ;
        end
    end

    // Saturating step targets computed in 11 bits so nothing wraps
    always_comb begin
        pos_ext  = {1'b0, posicion};
        suma     = pos_ext + STEP_W;
        pos_der  = (suma > MAX_W) ? MAX_P : suma[9:0];
        pos_izq  = (pos_ext < (MIN_W + STEP_W)) ? MIN_P
                                                 : posicion - STEP_W[9:0];
        pos_paso = (estado == DER) ? pos_der : pos_izq;
        paso     = (estado != REPOSO) && (cuenta == 20'd0);
    end

    // FSM, tick counter and position with registered status outputs
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            estado     <= REPOSO;
            cuenta     <= 20'd0;
            posicion   <= INIT_P;
            pulso_paso <= 1'b0;
            moviendo   <= 1'b0;
            direccion  <= 1'b0;
        end else begin
            estado    <= estado_sig;
            moviendo  <= (estado_sig != REPOSO);
            direccion <= (estado_sig == DER);

            if (estado_sig != estado || estado == REPOSO || icentrar) begin
                cuenta <= 20'd0;
            end else if (cuenta == CNT_LAST) begin
                cuenta <= 20'd0;
            end else begin
                cuenta <= cuenta + 20'd1;
            end

            if (icentrar) begin
                posicion   <= INIT_P;
                pulso_paso <= 1'b0;
            end else if (paso) begin
                posicion   <= pos_paso;
                pulso_paso <= (pos_paso != posicion);
            end else begin
                pulso_paso <= 1'b0;
            end
        end
    end

    assign borde_izq = (posicion == MIN_P);
    assign borde_der = (posicion == MAX_P);

endmodule

// File: tb/tb_movimiento_jugador.sv
// Directed bench for movimiento_jugador with a short tick divider.
// Expected positions and strobes are hand-derived from the step timing.
module tb_movimiento_jugador;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       der;
    logic       izq;
    logic       cen;
    logic [9:0] pos;
    logic       mov;
    logic       dir;
    logic       pulso;
    logic       b_izq;
    logic       b_der;

    int errors = 0;
    int checks = 0;
    int pulses;
    int bad;

    movimiento_jugador #(
        .TICK_DIV(4),
        .STEP(8)
    ) dut (
        .iclk(clk),
        .irst_n(rst_n),
        .derecha(der),
        .izquierda(izq),
        .icentrar(cen),
        .posicion(pos),
        .moviendo(mov),
        .direccion(dir),
        .pulso_paso(pulso),
        .borde_izq(b_izq),
        .borde_der(b_der)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check
    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int target, input int budget,
                            input string tag);
        int n;
        n = 0;
        while (pos != 10'(target) && n < budget) begin
            tick();
            n++;
        end
        check(tag, int'(pos), target);
    endtask

    initial begin
        rst_n = 1'b0;
        der   = 1'b0;
        izq   = 1'b0;
        cen   = 1'b0;
        tick();
        tick();
        check("rst_pos", int'(pos), 316);
        check("rst_mov", int'(mov), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_pulso", int'(pulso), 0);
        check("rst_bizq", int'(b_izq), 0);
        check("rst_bder", int'(b_der), 0);

        // Release with derecha held: steps on edges 3, 7, 11
        rst_n = 1'b1;
        der   = 1'b1;
        for (int e = 0; e < 12; e++) begin
            int ep;
            tick();
            ep = (e < 3) ? 316 : (e < 7) ? 324 : (e < 11) ? 332 : 340;
            check($sformatf("lat_pos_e%0d", e), int'(pos), ep);
            check($sformatf("lat_pulso_e%0d", e), int'(pulso),
                  (e == 3 || e == 7 || e == 11) ? 1 : 0);
            if (e == 2) begin
                check("der_mov", int'(mov), 1);
                check("der_dir", int'(dir), 1);
            end
        end

        // Right border saturation
        wait_pos(628, 400, "reach_628");
        repeat (3) begin
            tick();
            check("hold_628", int'(pos), 628);
        end
        tick();
        check("sat_pos", int'(pos), 632);
        check("sat_pulso", int'(pulso), 1);
        check("sat_bder", int'(b_der), 1);
        pulses = 0;
        bad    = 0;
        repeat (12) begin
            tick();
            pulses += int'(pulso);
            if (pos != 10'd632) bad++;
        end
        check("pin_der_pulses", pulses, 0);
        check("pin_der_moves", bad, 0);

        // Direct reversal DER -> IZQ
        der = 1'b0;
        izq = 1'b1;
        tick();
        tick();
        tick();
        check("rev_mov", int'(mov), 1);
        check("rev_dir", int'(dir), 0);
        check("rev_wait", int'(pos), 632);
        tick();
        check("rev_pos", int'(pos), 624);
        check("rev_pulso", int'(pulso), 1);

        // Recenter then walk left to the lower border
        cen = 1'b1;
        tick();
        cen = 1'b0;
        check("cen_pos", int'(pos), 316);
        check("cen_pulso", int'(pulso), 0);
        wait_pos(4, 400, "reach_4");
        repeat (3) begin
            tick();
            check("hold_4", int'(pos), 4);
        end
        tick();
        check("min_pos", int'(pos), 0);
        check("min_pulso", int'(pulso), 1);
        check("min_bizq", int'(b_izq), 1);
        pulses = 0;
        bad    = 0;
        repeat (7) begin
            tick();
            pulses += int'(pulso);
            if (pos != 10'd0) bad++;
        end
        check("pin_izq_pulses", pulses, 0);
        check("pin_izq_nowrap", bad, 0);

        // icentrar on a stepping edge wins and restarts the counter
        cen = 1'b1;
        tick();
        cen = 1'b0;
        check("cen_step_pos", int'(pos), 316);
        check("cen_step_pulso", int'(pulso), 0);
        tick();
        check("cen_restart_pos", int'(pos), 308);
        check("cen_restart_pulso", int'(pulso), 1);
        check("cen_bizq", int'(b_izq), 0);
        repeat (3) tick();
        check("cen_hold", int'(pos), 308);
        tick();
        check("cen_next", int'(pos), 300);

        // Reset pulse mid-move at position 500
        izq   = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        der   = 1'b1;
        wait_pos(500, 400, "reach_500");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_pos", int'(pos), 316);
        check("mid_rst_mov", int'(mov), 0);
        check("mid_rst_pulso", int'(pulso), 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("mid_rst_wait%0d", k), int'(pos), 316);
        end
        tick();
        check("mid_rst_step", int'(pos), 324);
        check("mid_rst_step_pulso", int'(pulso), 1);

        // Both requests held: stay at rest
        der   = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        der   = 1'b1;
        izq   = 1'b1;
        pulses = 0;
        bad    = 0;
        repeat (20) begin
            tick();
            pulses += int'(pulso);
            if (pos != 10'd316 || mov) bad++;
        end
        check("both_pulses", pulses, 0);
        check("both_bad", bad, 0);
        check("both_pos", int'(pos), 316);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
